// File: rtl/riscv_multicycle_control_if.sv
// Memory handshake bundle between the multi-cycle sequencer and the serial-backed memory.
// The sequencer is the master: it raises mem_req/mem_we, and memory answers with mem_ready.
interface riscv_multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/riscv_multicycle_control.sv
// Multi-cycle RISC-V sequencer: FETCH/DECODE/EXEC/MEM/WB with variable-latency memory handshake,
// illegal-opcode and memory-timeout faults, and a retired-instruction counter.
module riscv_multicycle_control #(
  parameter int unsigned MEM_TIMEOUT   = 255,
  parameter int unsigned INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     branch_cond,
  riscv_multicycle_control_if.master membus,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic [1:0]               pc_src,
  output logic                     reg_write,
  output logic [1:0]               wb_sel,
  output logic [1:0]               alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [6:0]               alu_op,
  output logic [2:0]               alu_funct3,
  output logic                     busy,
  output logic                     fault,
  output logic [1:0]               fault_code,
  output logic [3:0]               state,
  output logic [INSTRET_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // The Nth consecutive unanswered request cycle faults; a ready in that same cycle still completes.
  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_q, state_n;
  logic        taken_q;
  logic        fault_q;
  logic [1:0]  fault_code_q, fault_code_n;
  logic [15:0] tmo_cnt;
  logic        mem_req_c, mem_we_c;
  logic        tmo_hit;

  logic is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;

  always_comb begin
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    is_br    = (opcode == OP_BR);
    is_jal   = (opcode == OP_JAL);
    is_jalr  = (opcode == OP_JALR);
    is_lui   = (opcode == OP_LUI);
    is_auipc = (opcode == OP_AUIPC);
    legal    = is_r | is_i | is_load | is_store | is_br | is_jal | is_jalr | is_lui | is_auipc;
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST) && !membus.mem_ready;

  always_comb begin
    state_n      = state_q;
    fault_code_n = FC_NONE;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = '0;
    reg_write    = 1'b0;
    wb_sel       = '0;
    alu_src_a    = '0;
    alu_src_b    = '0;
    alu_op       = '0;
    alu_funct3   = '0;

    case (state_q)
      S_IDLE: begin
        if (run) state_n = S_FETCH;
      end

      S_FETCH: begin
        mem_req_c = 1'b1;
        if (membus.mem_ready) begin
          ir_write = 1'b1;
          state_n  = S_DECODE;
        end else if (tmo_hit) begin
          fault_code_n = FC_TIMEOUT;
          state_n      = S_FAULT;
        end
      end

      S_DECODE: begin
        if (!legal) begin
          fault_code_n = FC_ILLEGAL;
          state_n      = S_FAULT;
        end else begin
          state_n = S_EXEC;
        end
      end

      S_EXEC: begin
        // Control transfers reuse the ALU as a plain adder for the target address.
        if (is_br || is_jal || is_jalr) begin
          alu_op     = OP_STORE;
          alu_funct3 = 3'b000;
        end else begin
          alu_op     = opcode;
          alu_funct3 = funct3;
        end

        if (is_r) begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b00;
        end else if (is_i || is_load || is_store || is_jalr) begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end else if (is_lui) begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end else begin
          alu_src_a = 2'b00;
          alu_src_b = 2'b01;
        end

        state_n = (is_load || is_store) ? S_MEM : S_WB;
      end

      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_store;
        if (membus.mem_ready) begin
          state_n = S_WB;
        end else if (tmo_hit) begin
          fault_code_n = FC_TIMEOUT;
          state_n      = S_FAULT;
        end
      end

      S_WB: begin
        pc_write = 1'b1;
        if (is_jal || (is_br && taken_q)) pc_src = 2'b01;
        else if (is_jalr)                 pc_src = 2'b10;
        else                              pc_src = 2'b00;

        reg_write = !(is_store || is_br);

        if (is_load)               wb_sel = 2'b01;
        else if (is_jal || is_jalr) wb_sel = 2'b10;
        else                        wb_sel = 2'b00;

        state_n = run ? S_FETCH : S_IDLE;
      end

      S_FAULT: begin
        state_n = S_FAULT;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      taken_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      instret      <= '0;
      tmo_cnt      <= '0;
    end else begin
      state_q <= state_n;

      if (state_q == S_EXEC && is_br) taken_q <= branch_cond;

      if (state_n == S_FAULT && state_q != S_FAULT) begin
        fault_q      <= 1'b1;
        fault_code_q <= fault_code_n;
      end

      if (state_q == S_WB) instret <= instret + INSTRET_WIDTH'(1);

      if ((state_n == S_FETCH || state_n == S_MEM) && state_n != state_q)
        tmo_cnt <= '0;
      else if (mem_req_c && !membus.mem_ready)
        tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign membus.mem_req = mem_req_c;
  assign membus.mem_we  = mem_we_c;
  assign fault          = fault_q;
  assign fault_code     = fault_code_q;
  assign state          = state_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_FAULT);

endmodule
